// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter slice.
package mux16_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester/consumer bundle of the arbiter; slave is the arbiter side, master the environment.
interface mux16_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
);
    import mux16_rr_arbiter_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_flat;
    logic                          m_ready;
    logic [NUM_REQ-1:0]            gnt;
    logic [SEL_W-1:0]              sel;
    logic                          m_valid;
    logic [DATA_WIDTH-1:0]         m_data;
    logic [SEL_W-1:0]              m_src;
    logic [CNT_W-1:0]              beat_cnt;

    modport master (
        output req, data_flat, m_ready,
        input  gnt, sel, m_valid, m_data, m_src, beat_cnt
    );

    modport slave (
        input  req, data_flat, m_ready,
        output gnt, sel, m_valid, m_data, m_src, beat_cnt
    );

endinterface

// File: rtl/mux16_rr_arbiter_mux16.sv
// 16:1 datapath mux; picks one DATA_WIDTH slice of the flattened requester data.
module mux16_rr_arbiter_mux16
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_flat,
    input  logic [SEL_W-1:0]              sel,
    output logic [DATA_WIDTH-1:0]         y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == SEL_W'(i)) begin
                y = data_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 mux; each grant is capped at MAX_BURST beats.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no owner; arbitrate from ptr when any req is high (bubble cycle)
//   BUSY  | owner holds the mux; beats flow on m_valid && m_ready
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux16_rr_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   owner;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [SEL_W-1:0]   winner;
    logic               m_valid;
    logic               beat;
    logic               last_beat;

    // First requester at or after ptr, wrapping modulo 16.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = p + SEL_W'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign winner    = rr_pick(bus.req, ptr);
    assign m_valid   = (state == BUSY) && bus.req[owner];
    assign beat      = m_valid && bus.m_ready;
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state <= BUSY;
                        owner <= winner;
                        gnt_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // Owner dropping req wins over a completing last beat: no beat fires then.
                    if (!bus.req[owner] || (beat && last_beat)) begin
                        state <= IDLE;
                        ptr   <= owner + 1'b1;
                        gnt_q <= '0;
                        cnt_q <= '0;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux16_rr_arbiter_mux16 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .data_flat (bus.data_flat),
        .sel       (owner),
        .y         (bus.m_data)
    );

    assign bus.gnt      = gnt_q;
    assign bus.sel      = owner;
    assign bus.m_src    = owner;
    assign bus.m_valid  = m_valid;
    assign bus.beat_cnt = cnt_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed table-driven bench for mux16_rr_arbiter (DATA_WIDTH=32, MAX_BURST=4).
module tb_mux16_rr_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct {
        logic        pre_rst;
        logic [15:0] req;
        logic        rdy;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        mv;
        logic [2:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];

    mux16_rr_arbiter_if #(.DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

    mux16_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [15:0] g, input logic [3:0] s,
                           input logic mv, input logic [2:0] c);
        logic [31:0] exp_data;
        exp_data = 32'hA5A5_0000 | {28'd0, s};
        chk("gnt",      idx, {16'd0, bus.gnt},      {16'd0, g});
        chk("sel",      idx, {28'd0, bus.sel},      {28'd0, s});
        chk("m_src",    idx, {28'd0, bus.m_src},    {28'd0, s});
        chk("m_valid",  idx, {31'd0, bus.m_valid},  {31'd0, mv});
        chk("beat_cnt", idx, {29'd0, bus.beat_cnt}, {29'd0, c});
        chk("m_data",   idx, bus.m_data,            exp_data);
    endtask

    function automatic void add(input logic pr, input logic [15:0] rq, input logic rd,
                                input logic [15:0] g, input logic [3:0] s,
                                input logic mv, input logic [2:0] c);
        vec_t v;
        v.pre_rst = pr; v.req = rq; v.rdy = rd;
        v.gnt = g; v.sel = s; v.mv = mv; v.cnt = c;
        vecs.push_back(v);
    endfunction

    initial begin
        bus.req     = '0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus.data_flat[i*DW +: DW] = 32'hA5A5_0000 | i;

        // Single requester 3: grant, 4 beats, bubble, re-grant, owner drop
        add(1, 16'h0008, 1, 16'h0000, 4'd0, 0, 3'd0);
        add(0, 16'h0008, 1, 16'h0008, 4'd3, 1, 3'd0);
        add(0, 16'h0008, 1, 16'h0008, 4'd3, 1, 3'd1);
        add(0, 16'h0008, 1, 16'h0008, 4'd3, 1, 3'd2);
        add(0, 16'h0008, 1, 16'h0008, 4'd3, 1, 3'd3);
        add(0, 16'h0008, 1, 16'h0000, 4'd3, 0, 3'd0);
        add(0, 16'h0008, 1, 16'h0008, 4'd3, 1, 3'd0);
        add(0, 16'h0000, 1, 16'h0008, 4'd3, 0, 3'd1);
        add(0, 16'h0000, 1, 16'h0000, 4'd3, 0, 3'd0);
        // Contention 0 and 5 after reset
        add(1, 16'h0021, 1, 16'h0000, 4'd0, 0, 3'd0);
        for (int k = 0; k < 4; k++) add(0, 16'h0021, 1, 16'h0001, 4'd0, 1, 3'(k));
        add(0, 16'h0021, 1, 16'h0000, 4'd0, 0, 3'd0);
        for (int k = 0; k < 4; k++) add(0, 16'h0021, 1, 16'h0020, 4'd5, 1, 3'(k));
        add(0, 16'h0021, 1, 16'h0000, 4'd5, 0, 3'd0);
        add(0, 16'h0021, 1, 16'h0001, 4'd0, 1, 3'd0);
        add(0, 16'h0000, 1, 16'h0001, 4'd0, 0, 3'd1);
        // Wrap-around: grant 14 -> ptr 15 -> grant 15 -> ptr 0 -> grant 0
        add(0, 16'h4000, 1, 16'h0000, 4'd0, 0, 3'd0);
        add(0, 16'h0000, 1, 16'h4000, 4'd14, 0, 3'd0);
        add(0, 16'h8001, 1, 16'h0000, 4'd14, 0, 3'd0);
        for (int k = 0; k < 4; k++) add(0, 16'h8001, 1, 16'h8000, 4'd15, 1, 3'(k));
        add(0, 16'h8001, 1, 16'h0000, 4'd15, 0, 3'd0);
        add(0, 16'h8001, 1, 16'h0001, 4'd0, 1, 3'd0);
        add(0, 16'h0000, 1, 16'h0001, 4'd0, 0, 3'd1);
        // Back-pressure on owner 7
        add(0, 16'h0080, 0, 16'h0000, 4'd0, 0, 3'd0);
        for (int k = 0; k < 5; k++) add(0, 16'h0080, 0, 16'h0080, 4'd7, 1, 3'd0);
        add(0, 16'h0080, 1, 16'h0080, 4'd7, 1, 3'd0);
        add(0, 16'h0080, 1, 16'h0080, 4'd7, 1, 3'd1);
        add(0, 16'h0080, 0, 16'h0080, 4'd7, 1, 3'd2);
        add(0, 16'h0080, 1, 16'h0080, 4'd7, 1, 3'd2);
        add(0, 16'h0080, 1, 16'h0080, 4'd7, 1, 3'd3);
        add(0, 16'h0000, 1, 16'h0000, 4'd7, 0, 3'd0);
        // Early drop by owner 2 after 2 beats; ptr then 3
        add(0, 16'h0004, 1, 16'h0000, 4'd7, 0, 3'd0);
        add(0, 16'h0004, 1, 16'h0004, 4'd2, 1, 3'd0);
        add(0, 16'h0004, 1, 16'h0004, 4'd2, 1, 3'd1);
        add(0, 16'h0000, 1, 16'h0004, 4'd2, 0, 3'd2);
        add(0, 16'h000C, 1, 16'h0000, 4'd2, 0, 3'd0);
        add(0, 16'h000C, 1, 16'h0008, 4'd3, 1, 3'd0);
        add(0, 16'h0000, 1, 16'h0008, 4'd3, 0, 3'd1);
        add(0, 16'h0000, 1, 16'h0000, 4'd3, 0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].pre_rst) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            bus.req     = vecs[i].req;
            bus.m_ready = vecs[i].rdy;
            #1;
            chk_all(i, vecs[i].gnt, vecs[i].sel, vecs[i].mv, vecs[i].cnt);
        end

        // Asynchronous reset during owner 9's third beat
        @(posedge clk); #1;
        rst = 1'b1; #1; rst = 1'b0;
        bus.req = 16'h0200; bus.m_ready = 1'b1;
        #1; chk_all(100, 16'h0000, 4'd0, 0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            chk_all(101 + k, 16'h0200, 4'd9, 1, 3'(k));
        end
        rst = 1'b1;
        #1; chk_all(104, 16'h0000, 4'd0, 0, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 16'h0201;
        #1; chk_all(105, 16'h0000, 4'd0, 0, 3'd0);
        @(posedge clk); #2;
        chk_all(106, 16'h0001, 4'd0, 1, 3'd0);
        @(posedge clk); #2;
        chk_all(107, 16'h0001, 4'd0, 1, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
